// File: rtl/inner_fn_accum_pkg.sv
// Shared types and constants for the streaming fp32 sum accumulator.
//   state_t : accumulator FSM states
//   ADD_LAT : latency of fp_addsub_3cyc, issue to result
//   FP_ZERO : +0.0 in fp32
//   tag_t   : in-flight marker travelling alongside each adder issue
package inner_fn_accum_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        RED1,
        RED2,
        FIN
    } state_t;

    localparam int unsigned ADD_LAT = 3;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // red=0: partial-sum update for 'slot'; red=1: reduction step result
    typedef struct packed {
        logic       vld;
        logic       red;
        logic [1:0] slot;
    } tag_t;

endpackage

// File: rtl/fp_addsub_3cyc.sv
// Three-stage pipelined IEEE-754 single-precision adder/subtractor.
// Result appears on q three enabled clocks after a/b are presented.
// Round-to-nearest-even; subnormal results flush to signed zero.
//   clk    in  clock, rising edge
//   areset in  asynchronous, active-high reset
//   en     in  pipeline enable; all stages hold when low
//   opSel  in  1 = a+b, 0 = a-b
//   a, b   in  fp32 operands
//   q      out fp32 result
module fp_addsub_3cyc (
    input  logic        clk,
    input  logic        areset,
    input  logic        en,
    input  logic        opSel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q
);

    // ---- stage 1: unpack, order by magnitude, exponent difference ----
    logic [31:0] bx;
    logic [7:0]  ea, eb, ea_e, eb_e;
    logic [23:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        s1_sign_d, s1_sub_d, s1_spec_d;
    logic [7:0]  s1_exp_d, s1_sh_d;
    logic [23:0] s1_mb_d, s1_ms_d;
    logic [31:0] s1_sv_d;

    logic        s1_sign_q, s1_sub_q, s1_spec_q;
    logic [7:0]  s1_exp_q, s1_sh_q;
    logic [23:0] s1_mb_q, s1_ms_q;
    logic [31:0] s1_sv_q;

    always_comb begin
        bx    = {b[31] ^ ~opSel, b[30:0]};
        ea    = a[30:23];
        eb    = bx[30:23];
        ma    = {ea != 8'd0, a[22:0]};
        mb    = {eb != 8'd0, bx[22:0]};
        ea_e  = (ea == 8'd0) ? 8'd1 : ea;
        eb_e  = (eb == 8'd0) ? 8'd1 : eb;
        a_nan = (ea == 8'hFF) && (a[22:0] != '0);
        b_nan = (eb == 8'hFF) && (bx[22:0] != '0);
        a_inf = (ea == 8'hFF) && (a[22:0] == '0);
        b_inf = (eb == 8'hFF) && (bx[22:0] == '0);
        s1_sub_d = a[31] ^ bx[31];
        if (a[30:0] >= bx[30:0]) begin
            s1_sign_d = a[31];
            s1_exp_d  = ea_e;
            s1_mb_d   = ma;
            s1_ms_d   = mb;
            s1_sh_d   = ea_e - eb_e;
        end else begin
            s1_sign_d = bx[31];
            s1_exp_d  = eb_e;
            s1_mb_d   = mb;
            s1_ms_d   = ma;
            s1_sh_d   = eb_e - ea_e;
        end
        s1_spec_d = (ea == 8'hFF) || (eb == 8'hFF);
        if (a_nan || b_nan || (a_inf && b_inf && s1_sub_d)) begin
            s1_sv_d = 32'h7FC0_0000;
        end else if (a_inf) begin
            s1_sv_d = {a[31], 8'hFF, 23'd0};
        end else begin
            s1_sv_d = {bx[31], 8'hFF, 23'd0};
        end
    end

    // ---- stage 2: align smaller operand (with sticky), add or subtract ----
    logic [26:0] big_x, sml_x, sml_sh;
    logic        sticky;
    logic [27:0] s2_sum_d;

    logic        s2_sign_q, s2_zs_q, s2_spec_q;
    logic [7:0]  s2_exp_q;
    logic [27:0] s2_sum_q;
    logic [31:0] s2_sv_q;

    always_comb begin
        big_x = {s1_mb_q, 3'b000};
        sml_x = {s1_ms_q, 3'b000};
        if (s1_sh_q >= 8'd27) begin
            sml_sh = '0;
            sticky = |s1_ms_q;
        end else begin
            sml_sh = sml_x >> s1_sh_q;
            sticky = |(sml_x & ~({27{1'b1}} << s1_sh_q));
        end
        sml_sh[0] = sml_sh[0] | sticky;
        // big >= small in magnitude, so the difference never goes negative
        s2_sum_d = s1_sub_q ? ({1'b0, big_x} - {1'b0, sml_sh})
                            : ({1'b0, big_x} + {1'b0, sml_sh});
    end

    // ---- stage 3: normalise, round to nearest even, pack ----
    logic [4:0]        lz;
    logic [26:0]       nm;
    logic signed [9:0] ex;
    logic              rnd;
    logic [24:0]       mr;
    logic [31:0]       q_d;

    always_comb begin
        lz = '0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (s2_sum_q[i]) lz = 5'(26 - i);
        end
        ex = signed'({2'b00, s2_exp_q});
        if (s2_sum_q[27]) begin
            nm = {s2_sum_q[27:2], |s2_sum_q[1:0]};
            ex = ex + 10'sd1;
        end else begin
            nm = s2_sum_q[26:0] << lz;
            ex = ex - signed'({5'd0, lz});
        end
        rnd = nm[2] & (nm[1] | nm[0] | nm[3]);
        mr  = {1'b0, nm[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            ex = ex + 10'sd1;
        end
        if (s2_spec_q) begin
            q_d = s2_sv_q;
        end else if (s2_sum_q == '0) begin
            q_d = {s2_zs_q, 31'd0};
        end else if (ex >= 10'sd255) begin
            q_d = {s2_sign_q, 8'hFF, 23'd0};
        end else if (ex <= 10'sd0 || !mr[23]) begin
            q_d = {s2_sign_q, 31'd0};
        end else begin
            q_d = {s2_sign_q, ex[7:0], mr[22:0]};
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            s1_sign_q <= 1'b0;
            s1_sub_q  <= 1'b0;
            s1_spec_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_sh_q   <= '0;
            s1_mb_q   <= '0;
            s1_ms_q   <= '0;
            s1_sv_q   <= '0;
            s2_sign_q <= 1'b0;
            s2_zs_q   <= 1'b0;
            s2_spec_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_sum_q  <= '0;
            s2_sv_q   <= '0;
            q         <= '0;
        end else if (en) begin
            s1_sign_q <= s1_sign_d;
            s1_sub_q  <= s1_sub_d;
            s1_spec_q <= s1_spec_d;
            s1_exp_q  <= s1_exp_d;
            s1_sh_q   <= s1_sh_d;
            s1_mb_q   <= s1_mb_d;
            s1_ms_q   <= s1_ms_d;
            s1_sv_q   <= s1_sv_d;
            s2_sign_q <= s1_sign_q;
            s2_zs_q   <= s1_sign_q & ~s1_sub_q;
            s2_spec_q <= s1_spec_q;
            s2_exp_q  <= s1_exp_q;
            s2_sum_q  <= s2_sum_d;
            s2_sv_q   <= s1_sv_q;
            q         <= q_d;
        end
    end

endmodule

// File: rtl/inner_fn_sum_accum.sv
// Streaming fp32 accumulator: sums 'count' terms arriving on in_valid at up
// to one per cycle. Three interleaved partial sums hide the adder latency,
// then are reduced as (p0+p1)+p2.
//   clock    in  clock, rising edge
//   aclr_n   in  asynchronous, active-low reset
//   clk_en   in  global enable; all state and the adder hold when low
//   start    in  begin a new sum (IDLE only)
//   count    in  number of terms, sampled with start
//   in_valid in  term strobe
//   in_data  in  fp32 term
//   busy     out run in progress
//   done     out one-cycle pulse, sum valid
//   sum      out fp32 result, held until the next done
module inner_fn_sum_accum
    import inner_fn_accum_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             clk_en,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      sum
);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic [2:0][31:0]        p_q, p_d;
    logic [1:0]              slot_q, slot_d;
    tag_t [ADD_LAT-1:0]      tag_q;
    tag_t                    iss_tag, emerg;
    logic [31:0]             red_q, red_d;
    logic [31:0]             sum_q, sum_d;
    logic                    zero_q, zero_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [31:0]             op_a, op_b, add_q, p_sel;
    logic                    wb, early, any_flight;

    fp_addsub_3cyc u_add (
        .clk    (clock),
        .areset (~aclr_n),
        .en     (clk_en),
        .opSel  (1'b1),
        .a      (op_a),
        .b      (op_b),
        .q      (add_q)
    );

    always_comb begin
        emerg = tag_q[ADD_LAT-1];
        wb    = emerg.vld & ~emerg.red;
        early = 1'b0;
        for (int unsigned i = 0; i < ADD_LAT - 1; i++) begin
            early = early | tag_q[i].vld;
        end
        any_flight = early | emerg.vld;
        // a slot being written back this cycle must feed its new value forward
        p_sel = (wb && emerg.slot == slot_q) ? add_q : p_q[slot_q];
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        p_d     = p_q;
        slot_d  = slot_q;
        red_d   = red_q;
        sum_d   = sum_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        op_a    = FP_ZERO;
        op_b    = FP_ZERO;
        iss_tag = '0;

        if (wb) p_d[emerg.slot] = add_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d  = count;
                    p_d    = '0;
                    slot_d = '0;
                    busy_d = 1'b1;
                    zero_d = (count == '0);
                    state_d = (count == '0) ? FIN : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    op_a    = p_sel;
                    op_b    = in_data;
                    iss_tag = '{vld: 1'b1, red: 1'b0, slot: slot_q};
                    slot_d  = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // last writeback lands this cycle; p registers are final next cycle
                if (!early) state_d = RED1;
            end
            RED1: begin
                if (!any_flight) begin
                    op_a    = p_q[0];
                    op_b    = p_q[1];
                    iss_tag = '{vld: 1'b1, red: 1'b1, slot: 2'd0};
                end else if (emerg.vld && emerg.red) begin
                    red_d   = add_q;
                    state_d = RED2;
                end
            end
            RED2: begin
                if (!any_flight) begin
                    op_a    = red_q;
                    op_b    = p_q[2];
                    iss_tag = '{vld: 1'b1, red: 1'b1, slot: 2'd0};
                end else if (tag_q[ADD_LAT-2].vld && tag_q[ADD_LAT-2].red) begin
                    // enter FIN exactly as the final result reaches q
                    state_d = FIN;
                end
            end
            FIN: begin
                sum_d   = zero_q ? FP_ZERO : add_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            p_q     <= '0;
            slot_q  <= '0;
            tag_q   <= '0;
            red_q   <= '0;
            sum_q   <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            rem_q   <= rem_d;
            p_q     <= p_d;
            slot_q  <= slot_d;
            tag_q   <= {tag_q[ADD_LAT-2:0], iss_tag};
            red_q   <= red_d;
            sum_q   <= sum_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;

endmodule

// File: tb/tb_inner_fn_sum_accum.sv
module tb_inner_fn_sum_accum;

    logic        clock;
    logic        aclr_n;
    logic        clk_en;
    logic        start;
    logic [15:0] count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        busy;
    logic        done;
    logic [31:0] sum;

    inner_fn_sum_accum #(.CNT_W(16)) dut (
        .clock    (clock),
        .aclr_n   (aclr_n),
        .clk_en   (clk_en),
        .start    (start),
        .count    (count),
        .in_valid (in_valid),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .sum      (sum)
    );

    localparam logic [31:0] F1_0 = 32'h3F80_0000;
    localparam logic [31:0] F2_0 = 32'h4000_0000;
    localparam logic [31:0] F3_0 = 32'h4040_0000;
    localparam logic [31:0] F4_0 = 32'h4080_0000;
    localparam logic [31:0] F5_0 = 32'h40A0_0000;
    localparam logic [31:0] F2_5 = 32'h4020_0000;
    localparam logic [31:0] F0_5 = 32'h3F00_0000;

    typedef struct {
        logic [31:0] sum;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic done_prev = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clock) begin
        if (aclr_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: done at cycle %0d with sum 0x%08h, expected no done", cyc, sum);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_sum"}, sum, e.sum);
                    chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
                    chk({e.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
                    chk({e.name, "_done_width"}, {31'd0, done_prev}, 32'd0);
                end
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n, output int s);
        start = 1'b1;
        count = n;
        s     = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, output int l);
        in_valid = 1'b1;
        in_data  = d;
        l        = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [31:0] s, input int c);
        exp_t e;
        e.sum  = s;
        e.cyc  = c;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d results pending after %0d cycles, expected 0", name, sb.size(), n);
            sb.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        int s, l, f;
        logic [31:0] terms5 [5];
        terms5 = '{F1_0, F2_0, F3_0, F4_0, F5_0};

        aclr_n   = 1'b0;
        clk_en   = 1'b1;
        start    = 1'b0;
        count    = '0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_sum", sum, 32'h0);
        aclr_n = 1'b1;
        tick();

        // count=1: single term, done at L+12
        do_start(16'd1, s);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        send(F1_0, l);
        expect_result("one_term", F1_0, l + 12);
        wait_done("one_term");

        // count=4 back-to-back: bypass on every slot
        do_start(16'd4, s);
        send(F1_0, l);
        send(F2_0, l);
        send(F3_0, l);
        send(F4_0, l);
        expect_result("four_b2b", 32'h4120_0000, l + 12);
        wait_done("four_b2b");

        // count=5 with random gaps, 3 surplus strobes, and a start while busy
        do_start(16'd5, s);
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(4, 0)) tick();
            send(terms5[i], l);
        end
        expect_result("five_gaps", 32'h4170_0000, l + 12);
        for (int i = 0; i < 3; i++) send(F4_0, f);
        start = 1'b1;
        count = 16'd0;
        tick();
        start = 1'b0;
        wait_done("five_gaps");

        // reset mid-ACCUM clears outputs immediately
        do_start(16'd5, s);
        send(F1_0, l);
        send(F2_0, l);
        aclr_n = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_sum", sum, 32'h0);
        tick();
        tick();
        aclr_n = 1'b1;
        tick();
        do_start(16'd2, s);
        send(F2_5, l);
        send(F0_5, l);
        expect_result("after_reset", F3_0, l + 12);
        wait_done("after_reset");

        // count=0: done 2 cycles after start; a start one cycle later is ignored
        do_start(16'd0, s);
        expect_result("count_zero", 32'h0, s + 2);
        start = 1'b1;
        count = 16'd3;
        tick();
        start = 1'b0;
        tick();
        chk("ignored_start_busy", {31'd0, busy}, 32'd0);
        wait_done("count_zero");

        // count=6 of 1.0 with clk_en low for 5 cycles mid-stream
        do_start(16'd6, s);
        f = cyc;
        send(F1_0, l);
        send(F1_0, l);
        send(F1_0, l);
        clk_en   = 1'b0;
        in_valid = 1'b1;
        in_data  = F1_0;
        repeat (5) tick();
        clk_en = 1'b1;
        send(F1_0, l);
        send(F1_0, l);
        send(F1_0, l);
        // unstalled this would be f+5+12; the freeze adds exactly 5
        expect_result("clk_en_stall", 32'h40C0_0000, f + 5 + 12 + 5);
        wait_done("clk_en_stall");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/inner_fn_sum_accum.md
# inner_fn_sum_accum

Streaming floating-point accumulator directly downstream of the inner-function pipeline: it consumes one IEEE-754 single-precision term per `in_valid` pulse (the pipeline's `done`/`result` pair) and produces the sum of a programmed number of terms. It sustains one term per cycle through a single 3-cycle `fp_addsub_3cyc` adder by interleaving three partial sums, then reduces them. The final sum goes to the custom-instruction result register.

## Interface
- `CNT_W`, 16, width of the term-count input.
- `clock`  in  1  sole clock, rising edge.
- `aclr_n`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  global enable; when low, all state and the adder freeze.
- `start`  in  1  one-cycle pulse that begins a new sum; honoured only in IDLE.
- `count`  in  CNT_W  number of terms to accumulate, sampled with `start`.
- `in_valid`  in  1  term strobe, driven by the upstream `done`.
- `in_data`  in  32  term, fp32.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when `sum` is valid.
- `sum`  out  32  fp32 result; holds until the next `done`.

## Operation
- FSM states are IDLE, ACCUM, DRAIN, RED1, RED2 and FIN.
- **IDLE:** on `start`, load `remaining=count`, clear partials `p0..p2` to +0.0, and set slot=0.
  - If `count`=0, go to FIN with the result forced to +0.0.
  - Otherwise go to ACCUM.
- **ACCUM:** each cycle with `in_valid` is an accepted term. On acceptance:
  - Issue `a=P(slot)`, `b=in_data` to the adder.
  - Tag the issue with the slot and advance slot mod 3.
  - Decrement `remaining`. When it reaches 0, go to DRAIN.
- **Bypass:** `P(slot)` is the adder output `q` if that cycle's writeback targets the same slot; otherwise it is register `p[slot]`. Writebacks occur when the tagged result emerges 3 cycles after issue.
- `in_valid` in IDLE, DRAIN, RED*, FIN, or beyond `count`: the term is ignored and nothing is issued.
- **DRAIN:** wait until no issue is in flight.
- **RED1:** issue `p0+p1`.
- **RED2:** when that result emerges, issue `result+p2`.
- **FIN:** register the final result into `sum`, pulse `done`, and return to IDLE.
- Summation order is fixed: `sum=(p0+p1)+p2`, where `pk` is the in-order sum of terms whose index ≡ k mod 3. The bench model must use this order.
- Adder: one `fp_addsub_3cyc` with `opSel=1` (add), `areset=~aclr_n`, `en=clk_en`. The in-flight tag pipeline is also gated by `clk_en`.
- `start` outside IDLE is ignored; there is no abort.

## Timing
- On reset, all outputs are 0: `busy=0`, `done=0`, `sum=0x00000000`. State goes to IDLE, partials and tags clear, and `remaining=0`.
- Reset mid-operation discards everything. The first `start` after reset behaves as from power-up.
- With `clk_en` high throughout, let the last term be accepted in cycle L:
  - Its writeback is in L+3.
  - RED1 issues in L+4 and RED2 issues in L+8.
  - `done` is high in L+12, and `sum` is valid from L+12.
- Cycles with `clk_en` low extend every latency by exactly their number.
- With `count`=0, `done` pulses 2 cycles after the `start` cycle.
- Back-to-back terms are accepted at one per cycle with no stall. There is no backpressure output, so upstream must not exceed `count`.
- `busy` drops in the same cycle that `done` is high.

## Structure
- Package `inner_fn_accum_pkg` contains:
  - the state enum;
  - `ADD_LAT=3` (must equal the adder latency);
  - `FP_ZERO=32'h00000000`.
- No sub-module beyond the `fp_addsub_3cyc` instance. The operand mux, bypass, and the 3-deep tag shift register are inline.

## Test plan
- `count`=1, term 0x3F800000 → `sum`=0x3F800000, `done` at L+12.
- `count`=4, back-to-back terms 1.0, 2.0, 3.0, 4.0 → `sum`=0x41200000. This exercises bypass on every slot.
- `count`=5, terms 1.0..5.0 with random 0–4 cycle gaps and 3 extra `in_valid` pulses after the fifth term → `sum`=0x41700000; the extra pulses are ignored.
- `count`=0 → `done` 2 cycles after `start`, `sum`=0x00000000. A `start` during `busy` is ignored.
- `aclr_n` low mid-ACCUM → `busy`, `done` and `sum` are 0 immediately. A new `count`=2 run with 2.5, 0.5 → `sum`=0x40400000.
- `clk_en` low for 5 cycles mid-stream with `count`=6 (all 1.0) → `sum`=0x40C00000, and `done` is delayed by exactly 5 cycles.
